// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the seven-segment scan controller
package seg7_pkg;

  // Segment bit positions on the shared bus (a..g)
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = 7;

  // Every segment bit set; the dark pattern for active-low segment drive
  localparam logic [SEG_W-1:0] SEG_ALL = SEG_W'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                                (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                                (1 << SEG_G));

  // Hex digit to lit segments, active-high gfedcba
  localparam logic [SEG_W-1:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Ceiling log2, used to size counters from parameters
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to seven-segment decoder with blanking
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]       hex,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  logic [SEG_W-1:0] seg_lit;

  // Look up the lit pattern, suppress it when blanked, then apply pin polarity
  always_comb begin
    seg_lit = '0;
    if (!blank) begin
      seg_lit = HEX_SEG_TABLE[hex];
    end
    seg = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed multi-digit seven-segment scan controller
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_mask_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  input  logic                    enable_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int PRE_W = clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0]      PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_OFF   = SEG_ACTIVE_LOW ? SEG_ALL : '0;
  localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? '1 : '0;

  logic [PRE_W-1:0]      presc_q;
  logic [IDX_W-1:0]      idx_q;
  logic [VAL_W-1:0]      shadow_val_q;
  logic [NUM_DIGITS-1:0] shadow_dp_q;
  logic [VAL_W-1:0]      disp_val_q;
  logic [NUM_DIGITS-1:0] disp_dp_q;
  logic                  pending_q;

  logic                  tick;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [SEG_W-1:0]      seg_next;

  assign tick     = (presc_q == PRE_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  // Slot timer and digit index; index moves once per slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      if (tick) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  // Shadow capture and frame-synchronous display update; a load landing on
  // the boundary skips the shadow so it is not held back a whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_val_q <= value_i;
        shadow_dp_q  <= dp_mask_i;
      end
      if (boundary) begin
        pending_q <= 1'b0;
        if (load_i) begin
          disp_val_q <= value_i;
          disp_dp_q  <= dp_mask_i;
        end else if (pending_q) begin
          disp_val_q <= shadow_val_q;
          disp_dp_q  <= shadow_dp_q;
        end
      end else if (load_i) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Frame pulse in the cycle after the last slot ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_o <= 1'b0;
    end else begin
      frame_o <= boundary;
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run & (disp_val_q[4*k +: 4] == 4'h0);
      lz_blank[k] = blank_lz_i & zero_run & (k != 0);
    end
  end

  // Select nibble, dp, blank flag and anode of the digit under scan
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = disp_val_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = lz_blank[k];
        an_sel[k] = 1'b1;
      end
    end
  end

  seg7_hex_decode #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_hex_decode (
    .hex  (cur_nib),
    .blank(cur_blank),
    .seg  (seg_next)
  );

  // Registered pin drive; anodes stay dark early in each slot so the
  // previous digit's segments cannot ghost onto the new one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o <= SEG_OFF;
      dp_o  <= DP_OFF;
      an_o  <= AN_OFF;
    end else if (!enable_i) begin
      seg_o <= SEG_OFF;
      dp_o  <= DP_OFF;
      an_o  <= AN_OFF;
    end else begin
      seg_o <= seg_next;
      dp_o  <= cur_dp ^ SEG_ACTIVE_LOW;
      if (presc_q < PRE_BLANK) begin
        an_o <= AN_OFF;
      end else begin
        an_o <= AN_ACTIVE_LOW ? ~an_sel : an_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        rst_n;
  logic [15:0] value_i;
  logic [3:0]  dp_mask_i;
  logic        load_i;
  logic        blank_lz_i;
  logic        enable_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS    (4),
    .SCAN_DIV      (4),
    .BLANK_CYCLES  (1),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_i   (value_i),
    .dp_mask_i (dp_mask_i),
    .load_i    (load_i),
    .blank_lz_i(blank_lz_i),
    .enable_i  (enable_i),
    .seg_o     (seg_o),
    .dp_o      (dp_o),
    .an_o      (an_o),
    .frame_o   (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called with the state at (prescaler 0, index 0); returns at the next such point.
  // load_at = s raises load_i after sample s so it is captured with state s+1.
  task automatic check_frame(input string fname, input logic [15:0] val, input logic [3:0] dpm,
                             input logic blz, input logic en, input int load_at,
                             input logic [15:0] lval, input logic [3:0] ldp);
    int         k;
    int         j;
    logic [3:0] nib;
    logic [15:0] above;
    logic       blank;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    for (int s = 0; s < 16; s++) begin
      @(posedge clk);
      #1;
      load_i = 1'b0;
      k      = s / 4;
      j      = s % 4;
      nib    = val[4*k +: 4];
      above  = val >> (4 * k);
      blank  = blz && (k != 0) && (above == 16'h0000);
      if (!en) begin
        e_seg = 7'h7F;
        e_an  = 4'hF;
        e_dp  = 1'b1;
      end else begin
        e_seg = blank ? 7'h7F : ~HEX_TAB[nib];
        e_an  = (j == 0) ? 4'hF : (4'hF ^ (4'b0001 << k));
        e_dp  = ~dpm[k];
      end
      check($sformatf("%s s%0d an", fname, s), an_o, e_an);
      check($sformatf("%s s%0d seg", fname, s), seg_o, e_seg);
      check($sformatf("%s s%0d dp", fname, s), dp_o, e_dp);
      check($sformatf("%s s%0d frame", fname, s), frame_o, (s == 15));
      if (s == load_at) begin
        value_i   = lval;
        dp_mask_i = ldp;
        load_i    = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    value_i    = '0;
    dp_mask_i  = '0;
    load_i     = 1'b0;
    blank_lz_i = 1'b0;
    enable_i   = 1'b1;

    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset an", an_o, 4'hF);
      check("reset seg", seg_o, 7'h7F);
      check("reset dp", dp_o, 1'b1);
      check("reset frame", frame_o, 1'b0);
    end
    rst_n = 1'b1;

    check_frame("f0", 16'h0000, 4'h0, 1'b0, 1'b1, 1, 16'h1234, 4'h0);
    check("f0 pending", dut.pending_q, 1'b0);
    check_frame("f1", 16'h1234, 4'h0, 1'b0, 1'b1, 4, 16'hABCD, 4'h0);
    check("f1 pending", dut.pending_q, 1'b0);
    check_frame("f2", 16'hABCD, 4'h0, 1'b0, 1'b1, 14, 16'h00F0, 4'h0);
    check("coincident pending", dut.pending_q, 1'b0);
    check("coincident display", dut.disp_val_q, 16'h00F0);
    check_frame("f3", 16'h00F0, 4'h0, 1'b0, 1'b1, -1, 16'h0000, 4'h0);

    blank_lz_i = 1'b1;
    check_frame("f4", 16'h00F0, 4'h0, 1'b1, 1'b1, 2, 16'h0000, 4'b0100);
    check_frame("f5", 16'h0000, 4'b0100, 1'b1, 1'b1, -1, 16'h0000, 4'h0);

    enable_i = 1'b0;
    check_frame("f6", 16'h0000, 4'b0100, 1'b1, 1'b0, -1, 16'h0000, 4'h0);
    enable_i   = 1'b1;
    blank_lz_i = 1'b0;

    repeat (4) begin
      @(posedge clk);
      #1;
    end
    value_i   = 16'h5A5A;
    dp_mask_i = 4'hF;
    load_i    = 1'b1;
    @(posedge clk);
    #1;
    load_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pre-reset index", dut.idx_q, 2);
    check("pre-reset pending", dut.pending_q, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset an", an_o, 4'hF);
    check("async reset seg", seg_o, 7'h7F);
    check("async reset dp", dp_o, 1'b1);
    check("async reset index", dut.idx_q, 0);
    check("async reset pending", dut.pending_q, 1'b0);
    check("async reset display", dut.disp_val_q, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    check_frame("r0", 16'h0000, 4'h0, 1'b0, 1'b1, -1, 16'h0000, 4'h0);
    check_frame("r1", 16'h0000, 4'h0, 1'b0, 1'b1, -1, 16'h0000, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
